reg_file_mp: RTL and testbench
==============================

// Module: reg_file_mp
// PURPOSE
//  Parametrised multi-read-port CPU register file with a pending-write scoreboard.
//  Read data is registered (1-cycle latency). Register 0 is hard-wired to zero.
//  Sits between decode (read/reserve) and writeback (write/release) in the CPU pipeline.
// PARAMETERS
//  DATA_W   32   register width in bits (matches `WORD_SIZE)
//  ADDR_W   5    register address width; NREGS = 2**ADDR_W
//  NRD      2    number of independent read ports (1..4)
//  ZERO_REG 1    1: reg 0 reads 0, ignores writes, never busy; 0: reg 0 is ordinary
// PORTS
//  clk       in   1           clock, all state on rising edge
//  rst       in   1           asynchronous reset, active-high
//  rd_en     in   NRD         per-port read request
//  rd_addr   in   NRD*ADDR_W  per-port read address, port i at [i*ADDR_W +: ADDR_W]
//  rd_data   out  NRD*DATA_W  registered read data, port i at [i*DATA_W +: DATA_W]
//  rd_valid  out  NRD         1-cycle pulse: rd_data/rd_busy of port i updated
//  rd_busy   out  NRD         registered: addressed reg had a pending write at sample
//  wr_en     in   1           writeback strobe; also releases the scoreboard bit
//  wr_addr   in   ADDR_W      writeback address
//  wr_data   in   DATA_W      writeback data
//  rsv_en    in   1           reserve a destination (set its busy bit)
//  rsv_addr  in   ADDR_W      destination being reserved
//  busy_vec  out  NREGS       current scoreboard bits, unregistered view of state
// BEHAVIOUR
//  - Reset (async, any time, mid-operation included): all regs = 0, busy = 0,
//    rd_data = 0, rd_valid = 0, rd_busy = 0. Takes effect immediately; no posedge needed.
//  - Write: on posedge with wr_en, regs[wr_addr] <= wr_data (skipped for addr 0 if ZERO_REG).
//  - Read: on posedge with rd_en[i], rd_data[i] <= value, rd_busy[i] <= busy state,
//    rd_valid[i] <= 1. Without rd_en[i]: rd_data/rd_busy hold, rd_valid[i] <= 0.
//  - Ports are independent; any ports may read the same address in the same cycle.
//  - Scoreboard per reg: rsv_en sets bit; wr_en clears bit of wr_addr.
//    Same addr set+clear in one cycle: set wins (new reservation outstanding).
//    rsv_en to an already-busy reg: stays busy (no count, single outstanding write).
//    wr_en to a non-busy reg: legal, data written, bit stays 0.
//  - Addr 0 with ZERO_REG=1: reads return 0, rd_busy = 0, rsv/wr ignored.
//  - Read of addr A while wr_en to A in the same cycle: see CONFIGURATION.
//  - No arithmetic; widths are exact, no truncation or extension inside the block.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: same-cycle wr_en to rd_addr[i] forwards:
//    rd_data[i] <= wr_data, and rd_busy[i] <= 0 unless rsv_en also targets A this cycle.
//  REGFILE_BYPASS_EN undefined: read-before-write:
//    rd_data[i] <= old regs[A], rd_busy[i] <= old busy bit.
//  Addr 0 with ZERO_REG=1 is never forwarded.
// STRUCTURE
//  Shared package cpu_defs_pkg: WORD_SIZE constant, reg_addr_t (ADDR_W-bit) typedef,
//    REG_ZERO address constant.
//  One sub-module: regfile_scoreboard. It holds the busy bits, set/clear priority,
//    and the ZERO_REG mask, and exposes busy_vec.
//  Storage array, read registers and bypass muxes live in reg_file_mp.
// TESTING
//  1 rst mid-stream after writes -> rd_data = 0, rd_valid = 0, busy_vec = 0 before next edge.
//  2 wr r5 = 0xDEADBEEF; next cycle rd_en[0], rd_addr[0] = 5
//    -> following cycle rd_data[0] = 0xDEADBEEF, rd_valid[0] = 1.
//  3 wr r0 = 0x1234, rsv r0; read r0 on both ports
//    -> rd_data = 0, rd_busy = 0, busy_vec[0] = 0.
//  4 r7 = 0x11; same cycle wr r7 = 0x22 and read r7
//    -> bypass build: 0x22, rd_busy = 0; non-bypass build: 0x11.
//  5 rsv r3; read r3 -> rd_busy = 1; wr r3 and rsv r3 same cycle -> busy_vec[3] = 1.
//  6 NRD = 4: four ports read r1, r2, r1, r31 together -> each port shows its own value,
//    rd_valid = 4'b1111.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: machine word size, register address type and the
// address of the hard-wired zero register.
package cpu_defs_pkg;

    localparam int WORD_SIZE  = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by a decode-stage
// reservation and cleared by writeback; the zero register is never busy.
module regfile_scoreboard
    import cpu_defs_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rsv_en,
    input  logic [ADDR_W-1:0]      rsv_addr,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    output logic [2**ADDR_W-1:0]   busy_vec
);

    localparam int                NREGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(REG_ZERO);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_nxt;

    // Reservation is applied after release so a same-cycle set+clear leaves
    // the new reservation outstanding.
    always_comb begin
        busy_nxt = busy_q;
        if (wr_en)
            busy_nxt[wr_addr] = 1'b0;
        if (rsv_en)
            busy_nxt[rsv_addr] = 1'b1;
        if (ZERO_REG != 0)
            busy_nxt[ZADDR] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy_q <= '0;
        else
            busy_q <= busy_nxt;
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with registered reads and a pending-write
// scoreboard. Define REGFILE_BYPASS_EN to forward same-cycle writeback to reads.
module reg_file_mp
    import cpu_defs_pkg::*;
#(
    parameter int DATA_W   = WORD_SIZE,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NRD-1:0]         rd_en,
    input  logic [NRD*ADDR_W-1:0]  rd_addr,
    output logic [NRD*DATA_W-1:0]  rd_data,
    output logic [NRD-1:0]         rd_valid,
    output logic [NRD-1:0]         rd_busy,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   rsv_en,
    input  logic [ADDR_W-1:0]      rsv_addr,
    output logic [2**ADDR_W-1:0]   busy_vec
);

    localparam int                NREGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs [NREGS];
    logic              wr_commit;

    logic [ADDR_W-1:0] rd_addr_p0 [NRD];
    logic [DATA_W-1:0] rd_val_p0  [NRD];
    logic [NRD-1:0]    rd_bsy_p0;

    logic [DATA_W-1:0] rd_data_p1 [NRD];
    logic [NRD-1:0]    rd_busy_p1;
    logic [NRD-1:0]    vld_p1;

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .busy_vec (busy_vec)
    );

    assign wr_commit = wr_en && !((ZERO_REG != 0) && (wr_addr == ZADDR));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++)
                regs[r] <= '0;
        end else if (wr_commit) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // p0: per-port read value and busy state from current storage
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd_addr_p0[i] = rd_addr[i*ADDR_W +: ADDR_W];
            rd_val_p0[i]  = regs[rd_addr_p0[i]];
            rd_bsy_p0[i]  = busy_vec[rd_addr_p0[i]];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (wr_addr == rd_addr_p0[i])) begin
                rd_val_p0[i] = wr_data;
                rd_bsy_p0[i] = rsv_en && (rsv_addr == rd_addr_p0[i]);
            end
`endif
            if ((ZERO_REG != 0) && (rd_addr_p0[i] == ZADDR)) begin
                rd_val_p0[i] = '0;
                rd_bsy_p0[i] = 1'b0;
            end
        end
    end

    // p1: registered read outputs; data and busy hold when a port is idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NRD; i++)
                rd_data_p1[i] <= '0;
            rd_busy_p1 <= '0;
            vld_p1     <= '0;
        end else begin
            vld_p1 <= rd_en;
            for (int i = 0; i < NRD; i++) begin
                if (rd_en[i]) begin
                    rd_data_p1[i] <= rd_val_p0[i];
                    rd_busy_p1[i] <= rd_bsy_p0[i];
                end
            end
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd_out
        assign rd_data[g*DATA_W +: DATA_W] = rd_data_p1[g];
    end

    assign rd_busy  = rd_busy_p1;
    assign rd_valid = vld_p1;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp (4 read ports) with a queue of expected read
// results and a reference model of register contents and busy bits.
module tb_reg_file_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NRD    = 4;
    localparam int NREGS  = 2**ADDR_W;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NRD-1:0]        rd_en = '0;
    logic [NRD*ADDR_W-1:0] rd_addr = '0;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_valid;
    logic [NRD-1:0]        rd_busy;
    logic                  wr_en = 1'b0;
    logic [ADDR_W-1:0]     wr_addr = '0;
    logic [DATA_W-1:0]     wr_data = '0;
    logic                  rsv_en = 1'b0;
    logic [ADDR_W-1:0]     rsv_addr = '0;
    logic [NREGS-1:0]      busy_vec;

    reg_file_mp #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NRD      (NRD),
        .ZERO_REG (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .busy_vec (busy_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           port;
        logic [31:0]  data;
        logic         busy;
    } exp_t;

    exp_t              q[$];
    logic [DATA_W-1:0] mdl_regs [NREGS];
    logic [NREGS-1:0]  mdl_busy;
    logic [DATA_W-1:0] last_data [NRD];
    logic              last_busy [NRD];
    int                checks   = 0;
    int                failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++)
            mdl_regs[r] = '0;
        mdl_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            last_data[p] = '0;
            last_busy[p] = 1'b0;
        end
        q.delete();
    endtask

    // Set wr/rsv inputs before calling rd() in a step so bypass expectations see them.
    task automatic rd(input int p, input logic [ADDR_W-1:0] a);
        exp_t e;
        rd_en[p] = 1'b1;
        rd_addr[p*ADDR_W +: ADDR_W] = a;
        e.port = p;
        e.data = mdl_regs[a];
        e.busy = mdl_busy[a];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr == a) begin
            e.data = wr_data;
            e.busy = rsv_en && (rsv_addr == a);
        end
`endif
        if (a == 0) begin
            e.data = '0;
            e.busy = 1'b0;
        end
        q.push_back(e);
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
    endtask

    task automatic rsv(input logic [ADDR_W-1:0] a);
        rsv_en = 1'b1;
        rsv_addr = a;
    endtask

    task automatic cycle();
        logic [NRD-1:0] en_mask;
        exp_t e;
        en_mask = rd_en;
        @(posedge clk);
        #1;
        if (wr_en && wr_addr != 0)
            mdl_regs[wr_addr] = wr_data;
        if (wr_en)
            mdl_busy[wr_addr] = 1'b0;
        if (rsv_en)
            mdl_busy[rsv_addr] = 1'b1;
        mdl_busy[0] = 1'b0;
        chk("rd_valid", 64'(rd_valid), 64'(en_mask));
        while (q.size() > 0) begin
            e = q.pop_front();
            chk($sformatf("rd_data[%0d]", e.port), 64'(rd_data[e.port*DATA_W +: DATA_W]), 64'(e.data));
            chk($sformatf("rd_busy[%0d]", e.port), 64'(rd_busy[e.port]), 64'(e.busy));
            last_data[e.port] = e.data;
            last_busy[e.port] = e.busy;
        end
        for (int p = 0; p < NRD; p++) begin
            if (!en_mask[p]) begin
                chk($sformatf("hold_data[%0d]", p), 64'(rd_data[p*DATA_W +: DATA_W]), 64'(last_data[p]));
                chk($sformatf("hold_busy[%0d]", p), 64'(rd_busy[p]), 64'(last_busy[p]));
            end
        end
        chk("busy_vec", 64'(busy_vec), 64'(mdl_busy));
        rd_en  = '0;
        wr_en  = 1'b0;
        rsv_en = 1'b0;
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b1;
        #1;
        chk("reset_rd_valid", 64'(rd_valid), 64'h0);
        chk("reset_rd_data", 64'(rd_data[63:0]), 64'h0);
        chk("reset_busy_vec", 64'(busy_vec), 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // write r5, read it back next cycle
        wr(5'd5, 32'hDEADBEEF); rsv(5'd9);
        cycle();
        wr(5'd10, 32'h0000_00A5);
        rd(0, 5'd5);
        cycle();
        chk("t2_r5_const", 64'(rd_data[31:0]), 64'hDEADBEEF);
        chk("t2_valid_const", 64'(rd_valid[0]), 64'h1);
        rd(1, 5'd10); rd(2, 5'd9);
        cycle();

        // asynchronous reset mid-stream, checked before any clock edge
        rst = 1'b1;
        #1;
        chk("midrst_rd_valid", 64'(rd_valid), 64'h0);
        chk("midrst_rd_data_lo", 64'(rd_data[63:0]), 64'h0);
        chk("midrst_rd_data_hi", 64'(rd_data[127:64]), 64'h0);
        chk("midrst_rd_busy", 64'(rd_busy), 64'h0);
        chk("midrst_busy_vec", 64'(busy_vec), 64'h0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        rd(0, 5'd5); rd(3, 5'd10);
        cycle();

        // zero register: writes and reservations ignored
        wr(5'd0, 32'h1234); rsv(5'd0);
        cycle();
        rd(0, 5'd0); rd(1, 5'd0);
        cycle();
        chk("t3_busy0", 64'(busy_vec[0]), 64'h0);

        // same-cycle write and read of r7
        wr(5'd7, 32'h11);
        cycle();
        wr(5'd7, 32'h22);
        rd(2, 5'd7);
        cycle();
`ifdef REGFILE_BYPASS_EN
        chk("t4_r7_const", 64'(rd_data[95:64]), 64'h22);
`else
        chk("t4_r7_const", 64'(rd_data[95:64]), 64'h11);
`endif
        rd(2, 5'd7);
        cycle();

        // scoreboard: reserve, read busy, set+clear priority, release
        rsv(5'd3);
        cycle();
        rd(0, 5'd3);
        cycle();
        chk("t5_busy_const", 64'(rd_busy[0]), 64'h1);
        wr(5'd3, 32'h33); rsv(5'd3);
        rd(1, 5'd3);
        cycle();
        chk("t5_setwins", 64'(busy_vec[3]), 64'h1);
        rsv(5'd3);
        cycle();
        wr(5'd3, 32'h34);
        rd(0, 5'd3);
        cycle();
        chk("t5_release", 64'(busy_vec[3]), 64'h0);
        wr(5'd12, 32'hCAFE_0012);
        cycle();
        chk("t5_nonbusy_wr", 64'(busy_vec[12]), 64'h0);

        // four ports at once
        wr(5'd1, 32'h0101_0101);
        cycle();
        wr(5'd2, 32'h0202_0202);
        cycle();
        wr(5'd31, 32'hFFFF_0031); rsv(5'd31);
        cycle();
        rd(0, 5'd1); rd(1, 5'd2); rd(2, 5'd1); rd(3, 5'd31);
        cycle();
        chk("t6_valid_const", 64'(rd_valid), 64'hF);
        chk("t6_p3_const", 64'(rd_data[127:96]), 64'hFFFF_0031);

        // idle cycle: outputs hold, valid drops
        cycle();
        rd(1, 5'd12); rd(3, 5'd3);
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
